// File: rtl/regfile_multiport_if.sv
// rtl/regfile_multiport_if.sv - bus bundle for the multiport register file
interface regfile_multiport_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_PORTS    = 2,
  parameter int WRITE_PORTS   = 2
) ();
  logic [READ_PORTS*ADDRESS_WIDTH-1:0]  iReadAddress;
  logic [READ_PORTS*DATA_WIDTH-1:0]     oRegData;
  logic [READ_PORTS-1:0]                oBusy;
  logic [WRITE_PORTS-1:0]               iWriteEn;
  logic [WRITE_PORTS*ADDRESS_WIDTH-1:0] iWriteAddress;
  logic [WRITE_PORTS*DATA_WIDTH-1:0]    iDataIn;
  logic                                 iReserveEn;
  logic [ADDRESS_WIDTH-1:0]             iReserveAddress;
  logic [DATA_WIDTH-1:0]                oRegDebug;

  modport master (
    output iReadAddress, iWriteEn, iWriteAddress, iDataIn, iReserveEn, iReserveAddress,
    input  oRegData, oBusy, oRegDebug
  );

  modport slave (
    input  iReadAddress, iWriteEn, iWriteAddress, iDataIn, iReserveEn, iReserveAddress,
    output oRegData, oBusy, oRegDebug
  );
endinterface

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multiport register file with write bypass and busy scoreboard
module regfile_multiport #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_PORTS    = 2,
  parameter int WRITE_PORTS   = 2,
  parameter int DEBUG_REG     = 10
) (
  input logic          iClk,
  input logic          iRst,
  regfile_multiport_if.slave rf
);
  localparam int NREGS = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] DBG_ADDR = ADDRESS_WIDTH'(DEBUG_REG);

  logic [DATA_WIDTH-1:0]    regs [NREGS];
  logic [NREGS-1:0]         busy;

  logic [ADDRESS_WIDTH-1:0] rd_addr [READ_PORTS];
  logic [ADDRESS_WIDTH-1:0] wr_addr [WRITE_PORTS];
  logic [DATA_WIDTH-1:0]    wr_data [WRITE_PORTS];
  logic [DATA_WIDTH-1:0]    rd_next [READ_PORTS];
  logic [DATA_WIDTH-1:0]    rd_q    [READ_PORTS];
  logic [READ_PORTS-1:0]    busy_next;
  logic [READ_PORTS-1:0]    busy_q;

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    assign rd_addr[p] = rf.iReadAddress[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign rf.oRegData[p*DATA_WIDTH +: DATA_WIDTH] = rd_q[p];
  end

  for (genvar w = 0; w < WRITE_PORTS; w++) begin : g_wr
    assign wr_addr[w] = rf.iWriteAddress[w*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign wr_data[w] = rf.iDataIn[w*DATA_WIDTH +: DATA_WIDTH];
  end

  assign rf.oBusy     = busy_q;
  assign rf.oRegDebug = regs[DBG_ADDR];

  // Read values mirror the post-edge state: later write ports override earlier ones,
  // and a reservation overrides any write-side clear of the busy bit.
  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_next[p]   = regs[rd_addr[p]];
      busy_next[p] = busy[rd_addr[p]];
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (rf.iWriteEn[w] && wr_addr[w] == rd_addr[p]) begin
          rd_next[p]   = wr_data[w];
          busy_next[p] = 1'b0;
        end
      end
      if (rf.iReserveEn && rf.iReserveAddress == rd_addr[p]) begin
        busy_next[p] = 1'b1;
      end
      if (rd_addr[p] == '0) begin
        rd_next[p]   = '0;
        busy_next[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
      for (int p = 0; p < READ_PORTS; p++) begin
        rd_q[p] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (rf.iWriteEn[w] && wr_addr[w] != '0) begin
          regs[wr_addr[w]] <= wr_data[w];
          busy[wr_addr[w]] <= 1'b0;
        end
      end
      if (rf.iReserveEn && rf.iReserveAddress != '0) begin
        busy[rf.iReserveAddress] <= 1'b1;
      end
      for (int p = 0; p < READ_PORTS; p++) begin
        rd_q[p] <= rd_next[p];
      end
      busy_q <= busy_next;
    end
  end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - directed self-checking bench for regfile_multiport
module tb_regfile_multiport;
  logic iClk = 1'b0;
  logic iRst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  regfile_multiport_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .READ_PORTS(2), .WRITE_PORTS(2)) bus ();

  regfile_multiport #(
    .ADDRESS_WIDTH(5), .DATA_WIDTH(32), .READ_PORTS(2), .WRITE_PORTS(2), .DEBUG_REG(10)
  ) dut (
    .iClk(iClk),
    .iRst(iRst),
    .rf  (bus.slave)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.iReadAddress    = '0;
    bus.iWriteEn        = '0;
    bus.iWriteAddress   = '0;
    bus.iDataIn         = '0;
    bus.iReserveEn      = 1'b0;
    bus.iReserveAddress = '0;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    bus.iReadAddress[p*5 +: 5] = a;
  endtask

  task automatic wr(input int w, input logic [4:0] a, input logic [31:0] d);
    bus.iWriteEn[w]             = 1'b1;
    bus.iWriteAddress[w*5 +: 5] = a;
    bus.iDataIn[w*32 +: 32]     = d;
  endtask

  task automatic rsv(input logic [4:0] a);
    bus.iReserveEn      = 1'b1;
    bus.iReserveAddress = a;
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [31:0] data0();
    return bus.oRegData[31:0];
  endfunction

  function automatic logic [31:0] data1();
    return bus.oRegData[63:32];
  endfunction

  initial begin
    // Reset with garbage on every input: nothing may leak through
    idle();
    iRst = 1'b1;
    wr(0, 5'd6, 32'hCAFE_0006);
    rsv(5'd6);
    rd(0, 5'd6);
    tick();
    tick();
    check("rst_data0", data0(), 32'h0);
    check("rst_data1", data1(), 32'h0);
    check("rst_busy", {30'b0, bus.oBusy}, 32'h0);
    check("rst_debug", bus.oRegDebug, 32'h0);

    iRst = 1'b0;
    idle();
    rd(0, 5'd6);
    tick();
    check("rst_discard_wr", data0(), 32'h0);
    check("rst_discard_rsv", {31'b0, bus.oBusy[0]}, 32'h0);

    // Write then read one cycle later on another port
    idle();
    wr(0, 5'd5, 32'hDEAD_BEEF);
    tick();
    idle();
    rd(1, 5'd5);
    tick();
    check("wr_rd_p1", data1(), 32'hDEAD_BEEF);

    // Debug register shows array contents only, no bypass
    idle();
    wr(1, 5'd10, 32'hA5A5_0010);
    #1;
    check("debug_no_bypass", bus.oRegDebug, 32'h0);
    tick();
    check("debug_after_commit", bus.oRegDebug, 32'hA5A5_0010);

    // Same-cycle bypass
    idle();
    wr(0, 5'd7, 32'h1234_5678);
    rd(0, 5'd7);
    tick();
    check("bypass_p0", data0(), 32'h1234_5678);

    // Two writers to one register: port 1 wins
    idle();
    wr(0, 5'd3, 32'h1);
    wr(1, 5'd3, 32'h2);
    rd(0, 5'd3);
    rd(1, 5'd3);
    tick();
    check("prio_bypass_p0", data0(), 32'h2);
    check("prio_bypass_p1", data1(), 32'h2);
    idle();
    rd(0, 5'd3);
    tick();
    check("prio_array", data0(), 32'h2);

    // Register zero ignores writes and reservations
    idle();
    wr(0, 5'd0, 32'hFFFF_FFFF);
    wr(1, 5'd0, 32'hFFFF_FFFF);
    rsv(5'd0);
    rd(0, 5'd0);
    tick();
    check("x0_bypass_data", data0(), 32'h0);
    check("x0_bypass_busy", {31'b0, bus.oBusy[0]}, 32'h0);
    idle();
    rd(1, 5'd0);
    tick();
    check("x0_array_data", data1(), 32'h0);
    check("x0_array_busy", {31'b0, bus.oBusy[1]}, 32'h0);

    // Scoreboard: reserve, clear by write, reserve beats write
    idle();
    rsv(5'd9);
    rd(0, 5'd9);
    tick();
    check("rsv_same_cycle", {31'b0, bus.oBusy[0]}, 32'h1);
    idle();
    rd(0, 5'd9);
    tick();
    check("rsv_next_cycle", {31'b0, bus.oBusy[0]}, 32'h1);
    idle();
    wr(0, 5'd9, 32'h55);
    rd(0, 5'd9);
    rd(1, 5'd9);
    tick();
    check("wr_clear_data", data0(), 32'h55);
    check("wr_clear_busy", {31'b0, bus.oBusy[0]}, 32'h0);
    check("same_reg_data", data1(), 32'h55);
    check("same_reg_busy", {31'b0, bus.oBusy[1]}, 32'h0);
    idle();
    rd(0, 5'd9);
    tick();
    check("cleared_stays", {31'b0, bus.oBusy[0]}, 32'h0);
    idle();
    wr(1, 5'd9, 32'h66);
    rsv(5'd9);
    rd(0, 5'd9);
    tick();
    check("rsv_wins_data", data0(), 32'h66);
    check("rsv_wins_busy", {31'b0, bus.oBusy[0]}, 32'h1);
    idle();
    rd(1, 5'd9);
    tick();
    check("rsv_wins_array", {31'b0, bus.oBusy[1]}, 32'h1);

    // Fill the file, reserve x4, then reset mid-operation
    for (int i = 1; i < 32; i++) begin
      idle();
      wr(0, 5'(i), 32'h1000_0000 + 32'(i));
      tick();
    end
    idle();
    rsv(5'd4);
    tick();
    idle();
    rd(0, 5'd31);
    rd(1, 5'd4);
    tick();
    check("fill_x31", data0(), 32'h1000_001F);
    check("fill_x4_busy", {31'b0, bus.oBusy[1]}, 32'h1);
    check("fill_debug", bus.oRegDebug, 32'h1000_000A);

    idle();
    iRst = 1'b1;
    wr(1, 5'd12, 32'hBAD0_BAD0);
    rsv(5'd12);
    rd(0, 5'd31);
    rd(1, 5'd4);
    tick();
    check("midrst_data0", data0(), 32'h0);
    check("midrst_data1", data1(), 32'h0);
    check("midrst_busy", {30'b0, bus.oBusy}, 32'h0);
    check("midrst_debug", bus.oRegDebug, 32'h0);

    // First cycle after reset operates normally
    iRst = 1'b0;
    idle();
    wr(0, 5'd12, 32'h77);
    rd(0, 5'd12);
    rd(1, 5'd4);
    tick();
    check("post_rst_bypass", data0(), 32'h77);
    check("post_rst_x4_data", data1(), 32'h0);
    check("post_rst_x4_busy", {31'b0, bus.oBusy[1]}, 32'h0);
    idle();
    rd(0, 5'd31);
    rd(1, 5'd12);
    tick();
    check("post_rst_x31", data0(), 32'h0);
    check("post_rst_x12", data1(), 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
